fetchbuf_pf_ctrl: RTL and testbench
===================================

# fetchbuf_pf_ctrl

Next-line prefetch scheduler and I$ read-port arbiter for the IFU fetch buffer. It shares the single instruction-cache read port between demand fetches, which miss the fetch buffer, and next-line prefetches into the buffer's non-active line slot. Demand requests always have priority, and at most one cache request is in flight. A prefetch already in flight is never aborted by a demand; only a flush or reset drops it.

## Interface
Parameters:
- PA_BITS, 56, physical address width
- PF_THRESH, 16, half-word index within the active line (ActivePAdr[5:1]) at or above which a prefetch becomes eligible

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- FlushStage  in  1  fetch-stage flush; synchronous, same effect as reset except PFCount is kept
- Stall  in  1  pipeline stall; freezes state and suppresses completion
- DemandValid  in  1  fetch buffer misses and needs the line containing DemandPAdr
- DemandPAdr  in  PA_BITS  demand address
- ActivePAdr  in  PA_BITS  PAdr of the fetch buffer's active line and current half-word
- NextLineValid  in  1  non-active slot already holds line ActivePAdr+64
- CacheStall  in  1  I$ busy with the current request
- CacheReqValid  out  1  request presented to I$ (registered)
- CacheReqPAdr  out  PA_BITS  request address, line-aligned ([5:0]=0) (registered)
- CacheReqIsPF  out  1  current request is a prefetch (registered)
- DemandFill  out  1  pulse: the returned line satisfies the demand; write it to the active slot
- PFFill  out  1  pulse: write the returned line to the non-active slot
- PFCount  out  16  saturating count of PFFill pulses

## Operation
- States: IDLE, DEMAND, PREFETCH, PF_THEN_DEMAND.
- Completion is defined as Done = CacheReqValid & ~CacheStall & ~Stall.
- NextLine = {ActivePAdr[PA_BITS-1:6]+1, 6'b0}. Arithmetic is modulo 2^PA_BITS; the all-ones line wraps to 0.
- Prefetch eligibility: PFEligible = ActivePAdr[5:1] >= PF_THRESH & ~NextLineValid & ~PFIssued & PageOK.
  - PFIssued is a flag. It sets on entry to PREFETCH.
  - It clears when ActivePAdr[PA_BITS-1:6] differs from its value in the previous cycle, and on reset or flush.
- IDLE transitions:
  - DemandValid → DEMAND, with CacheReqPAdr = DemandPAdr line.
  - Otherwise PFEligible → PREFETCH, with CacheReqPAdr = NextLine and CacheReqIsPF=1.
  - When both are true, demand wins.
- DEMAND: on Done, assert DemandFill and go to IDLE.
- PREFETCH: on Done, assert PFFill.
  - If DemandValid and the DemandPAdr line equals CacheReqPAdr, also assert DemandFill in the same cycle and go to IDLE.
  - Otherwise go to IDLE.
  - If DemandValid for a different line is seen before Done, go to PF_THEN_DEMAND.
- PF_THEN_DEMAND: on Done, assert PFFill, then go to DEMAND for the latched demand line. CacheReqValid stays high across this transition with no idle cycle.
- Stall: state, request outputs and flags hold. Fill pulses are suppressed.
- PFCount increments on each PFFill and saturates at 0xFFFF. It is cleared by reset only.

## Timing
- Reset and flush values:
  - state=IDLE
  - CacheReqValid=0, CacheReqPAdr=0, CacheReqIsPF=0
  - DemandFill=0, PFFill=0
  - PFIssued=0
  - PFCount=0 on reset, unchanged on flush
- Issue latency: a request decided in IDLE in cycle n drives CacheReqValid=1 in cycle n+1.
- Fill pulses are combinational from Done and last exactly one cycle per completion.
- CacheReqPAdr and CacheReqIsPF are stable while CacheReqValid=1 and CacheStall=1.
- A flush while a request is in flight drops it. No fill pulse fires, even if CacheStall falls in the same cycle.
- Back-to-back demands: at least one IDLE cycle separates a DemandFill and the next request, except on the PF_THEN_DEMAND path.

## Configuration
- FETCHBUF_PF_PAGECROSS_EN
  - Defined: PageOK=1, so prefetch may cross a 4 KiB page.
  - Undefined: PageOK = ~&ActivePAdr[11:6], so no prefetch is issued from the last line of a page. Demand fetches are unaffected.

## Test plan
- Reset, then ActivePAdr=0x1000+2*16 with NextLineValid=0 → CacheReqValid=1 and CacheReqPAdr=0x1040 one cycle later with CacheReqIsPF=1. With CacheStall low, PFFill=1 for 1 cycle and PFCount=1.
- DemandValid with DemandPAdr=0x2008 and PF-eligible in the same IDLE cycle → demand issued (CacheReqPAdr=0x2000, IsPF=0). DemandFill pulses; the prefetch issues afterward.
- Prefetch to 0x1040 in flight with CacheStall=1 for 3 cycles, then DemandValid for 0x3000 → PFFill, then a CacheReqPAdr=0x3000 request with no gap, then DemandFill.
- Prefetch to 0x1040 in flight, DemandValid for 0x1044 → a single completion asserts PFFill and DemandFill together; state returns to IDLE.
- FlushStage during an in-flight prefetch with CacheStall dropping the same cycle → no fill pulse, CacheReqValid=0 the next cycle, PFCount unchanged.
- ActivePAdr=0x1FFE (last line of the page), eligible → with FETCHBUF_PF_PAGECROSS_EN, a request to 0x2000 is issued; without it, no request. Also force 65536 PFFills → PFCount holds at 0xFFFF.

Source files
------------

// File: rtl/fetchbuf_pf_ctrl.sv
// fetchbuf_pf_ctrl: next-line prefetch scheduler and I$ read-port arbiter
// for the IFU fetch buffer.
//
// One cache request is outstanding at a time. Demand fetches win over
// prefetches. An in-flight prefetch is never aborted by a demand. It is
// dropped only by reset or FlushStage.
//
// Optional feature macro: FETCHBUF_PF_PAGECROSS_EN
//   defined   : prefetches may cross a 4 KiB page boundary
//   undefined : no prefetch is issued from the last line of a page
//
// Handshake: CacheReqValid/CacheReqPAdr/CacheReqIsPF are registered and held
// while CacheStall=1. A request completes in the first cycle where
// CacheReqValid=1, CacheStall=0 and Stall=0. That cycle produces exactly one
// fill pulse (DemandFill and/or PFFill). The next request, if any, is driven
// from the following cycle.
module fetchbuf_pf_ctrl #(
  parameter int PA_BITS   = 56,
  parameter int PF_THRESH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               FlushStage,
  input  logic               Stall,
  input  logic               DemandValid,
  input  logic [PA_BITS-1:0] DemandPAdr,
  input  logic [PA_BITS-1:0] ActivePAdr,
  input  logic               NextLineValid,
  input  logic               CacheStall,
  output logic               CacheReqValid,
  output logic [PA_BITS-1:0] CacheReqPAdr,
  output logic               CacheReqIsPF,
  output logic               DemandFill,
  output logic               PFFill,
  output logic [15:0]        PFCount,
  output logic [1:0]         dbg_state
);

  localparam int LINE_BITS = PA_BITS - 6;
  localparam logic [5:0] THRESH = 6'(PF_THRESH);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    DEMAND         = 2'd1,
    PREFETCH       = 2'd2,
    PF_THEN_DEMAND = 2'd3
  } state_t;

  state_t               state;
  logic                 pf_issued;
  logic [LINE_BITS-1:0] prev_line;
  logic [LINE_BITS-1:0] pend_line;
  logic [15:0]          pf_count;
  logic [15:0]          pf_count_nxt;

  logic [LINE_BITS-1:0] active_line;
  logic [LINE_BITS-1:0] demand_line;
  logic [LINE_BITS-1:0] next_line;
  logic                 line_changed;
  logic                 pf_issued_now;
  logic                 hw_above;
  logic                 page_ok;
  logic                 pf_eligible;
  logic                 done;
  logic                 kill;
  logic                 same_line;

  assign active_line = ActivePAdr[PA_BITS-1:6];
  assign demand_line = DemandPAdr[PA_BITS-1:6];
  // Line arithmetic wraps naturally: the all-ones line rolls over to 0.
  assign next_line   = active_line + LINE_BITS'(1);

  // A change of active line this cycle already counts as clearing the flag,
  // so a new line is eligible in its first cycle.
  assign line_changed  = (active_line != prev_line);
  assign pf_issued_now = pf_issued & ~line_changed;

  assign hw_above = ({1'b0, ActivePAdr[5:1]} >= THRESH);

`ifdef FETCHBUF_PF_PAGECROSS_EN
  assign page_ok = 1'b1;
`else
  assign page_ok = ~&ActivePAdr[11:6];
`endif

  assign pf_eligible = hw_above & ~NextLineValid & ~pf_issued_now & page_ok;
  assign done        = CacheReqValid & ~CacheStall & ~Stall;
  assign kill        = reset | FlushStage;
  assign same_line   = (demand_line == CacheReqPAdr[PA_BITS-1:6]);

  // Fill pulses: combinational from completion, suppressed by reset/flush.
  always_comb begin
    DemandFill = 1'b0;
    PFFill     = 1'b0;
    if (done && !kill) begin
      case (state)
        DEMAND:         DemandFill = 1'b1;
        PREFETCH: begin
          PFFill     = 1'b1;
          DemandFill = DemandValid & same_line;
        end
        PF_THEN_DEMAND: PFFill = 1'b1;
        default: ;
      endcase
    end
  end

  // Request FSM with registered request outputs and the prefetch-issued flag.
  always_ff @(posedge clk) begin
    if (kill) begin
      state         <= IDLE;
      CacheReqValid <= 1'b0;
      CacheReqPAdr  <= '0;
      CacheReqIsPF  <= 1'b0;
      pend_line     <= '0;
      pf_issued     <= 1'b0;
    end else if (!Stall) begin
      if (line_changed) pf_issued <= 1'b0;
      case (state)
        IDLE: begin
          if (DemandValid) begin
            state         <= DEMAND;
            CacheReqValid <= 1'b1;
            CacheReqPAdr  <= {demand_line, 6'b0};
            CacheReqIsPF  <= 1'b0;
          end else if (pf_eligible) begin
            state         <= PREFETCH;
            CacheReqValid <= 1'b1;
            CacheReqPAdr  <= {next_line, 6'b0};
            CacheReqIsPF  <= 1'b1;
            pf_issued     <= 1'b1;
          end
        end
        DEMAND: begin
          if (done) begin
            state         <= IDLE;
            CacheReqValid <= 1'b0;
          end
        end
        PREFETCH: begin
          if (done) begin
            state         <= IDLE;
            CacheReqValid <= 1'b0;
          end else if (DemandValid && !same_line) begin
            state     <= PF_THEN_DEMAND;
            pend_line <= demand_line;
          end
        end
        PF_THEN_DEMAND: begin
          // Request stays valid: the latched demand follows with no gap.
          if (done) begin
            state        <= DEMAND;
            CacheReqPAdr <= {pend_line, 6'b0};
            CacheReqIsPF <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          CacheReqValid <= 1'b0;
        end
      endcase
    end
  end

  // Track the active line of the previous (unstalled) cycle.
  always_ff @(posedge clk) begin
    if (reset) prev_line <= '0;
    else if (!Stall) prev_line <= active_line;
  end

  // Saturating prefetch fill counter; flush leaves it alone.
  always_comb begin
    pf_count_nxt = pf_count;
    if (PFFill && (pf_count != 16'hFFFF)) pf_count_nxt = pf_count + 16'd1;
  end

  // Counter register, written every cycle from its next-value logic.
  always_ff @(posedge clk) begin
    if (reset) pf_count <= 16'd0;
    else pf_count <= pf_count_nxt;
  end

  assign PFCount   = pf_count;
  assign dbg_state = state;

endmodule

// File: tb/tb_fetchbuf_pf_ctrl.sv
// tb_fetchbuf_pf_ctrl: table-driven bench for fetchbuf_pf_ctrl, plus a
// hand-written saturation and reset sequence for PFCount.
// Honours FETCHBUF_PF_PAGECROSS_EN for the page-end prefetch rows.
module tb_fetchbuf_pf_ctrl;

`ifdef FETCHBUF_PF_PAGECROSS_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        FlushStage;
  logic        Stall;
  logic        DemandValid;
  logic [55:0] DemandPAdr;
  logic [55:0] ActivePAdr;
  logic        NextLineValid;
  logic        CacheStall;
  logic        CacheReqValid;
  logic [55:0] CacheReqPAdr;
  logic        CacheReqIsPF;
  logic        DemandFill;
  logic        PFFill;
  logic [15:0] PFCount;
  logic [1:0]  dbg_state;

  fetchbuf_pf_ctrl #(.PA_BITS(56), .PF_THRESH(16)) dut (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .Stall(Stall),
    .DemandValid(DemandValid), .DemandPAdr(DemandPAdr), .ActivePAdr(ActivePAdr),
    .NextLineValid(NextLineValid), .CacheStall(CacheStall),
    .CacheReqValid(CacheReqValid), .CacheReqPAdr(CacheReqPAdr),
    .CacheReqIsPF(CacheReqIsPF), .DemandFill(DemandFill), .PFFill(PFFill),
    .PFCount(PFCount), .dbg_state(dbg_state)
  );

  // Clock and initial input values.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;   // {reset, FlushStage, Stall, DemandValid}
    logic [55:0] dpa;
    logic [55:0] apa;
    logic [1:0]  cin;   // {NextLineValid, CacheStall}
    logic [3:0]  ex;    // {CacheReqValid, CacheReqIsPF, DemandFill, PFFill}
    logic [55:0] ea;    // expected CacheReqPAdr, checked only when valid
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [55:0] dpa,
                              input logic [55:0] apa, input logic [1:0] cin,
                              input logic [3:0] ex, input logic [55:0] ea,
                              input logic [15:0] ecnt);
    vec_t v;
    v.ctl = ctl; v.dpa = dpa; v.apa = apa; v.cin = cin;
    v.ex = ex; v.ea = ea; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {reset, FlushStage, Stall, DemandValid} = v.ctl;
    DemandPAdr = v.dpa;
    ActivePAdr = v.apa;
    {NextLineValid, CacheStall} = v.cin;
  endtask

  logic [15:0] exp_cnt;
  logic        seen;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; FlushStage = 1'b0; Stall = 1'b0; DemandValid = 1'b0;
    DemandPAdr = '0; ActivePAdr = '0; NextLineValid = 1'b0; CacheStall = 1'b0;

    // Reset and basic prefetch (NextLineValid blocks first)
    tbl.push_back(mk(4'b1000, 56'h0,    56'h0,    2'b00, 4'b0000, 56'h0,    16'd0));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b11, 4'b0000, 56'h0,    16'd0));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd0));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd0));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b1101, 56'h1040, 16'd0));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b0000, 56'h0,    16'd1));
    // Demand wins over an eligible prefetch; prefetch follows
    tbl.push_back(mk(4'b0001, 56'h2008, 56'h1060, 2'b01, 4'b0000, 56'h0,    16'd1));
    tbl.push_back(mk(4'b0001, 56'h2008, 56'h1060, 2'b01, 4'b1000, 56'h2000, 16'd1));
    tbl.push_back(mk(4'b0001, 56'h2008, 56'h1060, 2'b00, 4'b1010, 56'h2000, 16'd1));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1060, 2'b01, 4'b0000, 56'h0,    16'd1));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1060, 2'b01, 4'b1100, 56'h1080, 16'd1));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1060, 2'b00, 4'b1101, 56'h1080, 16'd1));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1060, 2'b00, 4'b0000, 56'h0,    16'd2));
    // Prefetch stalled 3 cycles, then different-line demand: no-gap handoff
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd2));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd2));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd2));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd2));
    tbl.push_back(mk(4'b0001, 56'h3000, 56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd2));
    tbl.push_back(mk(4'b0001, 56'h3000, 56'h1020, 2'b00, 4'b1101, 56'h1040, 16'd2));
    tbl.push_back(mk(4'b0001, 56'h3000, 56'h1020, 2'b01, 4'b1000, 56'h3000, 16'd3));
    tbl.push_back(mk(4'b0001, 56'h3000, 56'h1020, 2'b00, 4'b1010, 56'h3000, 16'd3));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b0000, 56'h0,    16'd3));
    // Same-line demand during prefetch: joint completion
    tbl.push_back(mk(4'b0000, 56'h0,    56'h0,    2'b01, 4'b0000, 56'h0,    16'd3));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd3));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd3));
    tbl.push_back(mk(4'b0001, 56'h1044, 56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd3));
    tbl.push_back(mk(4'b0001, 56'h1044, 56'h1020, 2'b00, 4'b1111, 56'h1040, 16'd3));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b0000, 56'h0,    16'd4));
    // Flush with CacheStall falling in the same cycle drops the prefetch
    tbl.push_back(mk(4'b0000, 56'h0,    56'h0,    2'b01, 4'b0000, 56'h0,    16'd4));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd4));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b1100, 56'h1040, 16'd4));
    tbl.push_back(mk(4'b0100, 56'h0,    56'h1020, 2'b00, 4'b1100, 56'h1040, 16'd4));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd4));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b1101, 56'h1040, 16'd4));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b0000, 56'h0,    16'd5));
    // Stall holds IDLE, then suppresses completion
    tbl.push_back(mk(4'b0000, 56'h0,    56'h0,    2'b01, 4'b0000, 56'h0,    16'd5));
    tbl.push_back(mk(4'b0010, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd5));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b01, 4'b0000, 56'h0,    16'd5));
    tbl.push_back(mk(4'b0010, 56'h0,    56'h1020, 2'b00, 4'b1100, 56'h1040, 16'd5));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b1101, 56'h1040, 16'd5));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1020, 2'b00, 4'b0000, 56'h0,    16'd6));
    // Last line of a page
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1FFE, 2'b01, 4'b0000, 56'h0,    16'd6));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1FFE, 2'b01, PC ? 4'b1100 : 4'b0000, 56'h2000, 16'd6));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1FFE, 2'b00, PC ? 4'b1101 : 4'b0000, 56'h2000, 16'd6));
    tbl.push_back(mk(4'b0000, 56'h0,    56'h1FFE, 2'b00, 4'b0000, 56'h0, PC ? 16'd7 : 16'd6));

    // Apply each row at the falling edge, compare just after.
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("CacheReqValid", i, 64'(CacheReqValid), 64'(tbl[i].ex[3]));
      chk("DemandFill",    i, 64'(DemandFill),    64'(tbl[i].ex[1]));
      chk("PFFill",        i, 64'(PFFill),        64'(tbl[i].ex[0]));
      chk("PFCount",       i, 64'(PFCount),       64'(tbl[i].ecnt));
      if (tbl[i].ex[3]) begin
        chk("CacheReqPAdr", i, 64'(CacheReqPAdr), 64'(tbl[i].ea));
        chk("CacheReqIsPF", i, 64'(CacheReqIsPF), 64'(tbl[i].ex[2]));
      end
    end

    // PFCount saturation: preload near the top, then drive real prefetches.
    @(negedge clk);
    DemandValid = 1'b0; CacheStall = 1'b1; ActivePAdr = 56'h1FFE;
    force dut.pf_count = 16'hFFFD;
    repeat (2) @(negedge clk);
    release dut.pf_count;
    #1;
    exp_cnt = 16'hFFFD;
    chk("pfcount_preload", 100, 64'(PFCount), 64'(exp_cnt));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ActivePAdr = (i % 2 == 0) ? 56'h1020 : 56'h1060;
      CacheStall = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        #1;
        if (PFFill) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("pf_fill_seen", 101 + i, 64'(seen), 64'd1);
      @(negedge clk);
      #1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      chk("pfcount_sat", 101 + i, 64'(PFCount), 64'(exp_cnt));
    end

    // Reset clears the counter and the request.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    CacheStall = 1'b1;
    ActivePAdr = 56'h0;
    #1;
    chk("pfcount_reset", 110, 64'(PFCount), 64'd0);
    chk("valid_reset",   110, 64'(CacheReqValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
